// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard/forwarding controller:
//   default index and counter widths, the forwarding-select encoding
//   and a helper that sizes the operand-select field for a given
//   number of forwarding sources.
package hazard_pkg;

  localparam int RAW_DEF   = 5;
  localparam int CNT_W_DEF = 16;

  // Operand-select encoding: 0 selects the register file, k selects
  // forwarding source k-1 (source 0 is the youngest, i.e. MEM).
  typedef logic [2:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF = 3'd0;

  // Width of the operand-select field for nfwd forwarding sources.
  function automatic int fsw_of(input int nfwd);
    return $clog2(nfwd + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_mc_scoreboard.sv
// mc_scoreboard
//   Tracks the single variable-latency (mul/div) unit: a latency
//   down-counter, the destination of the op in flight, and a
//   per-register pending vector used for decode RAW/WAW stalls.
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   mc_start_e    op enters the unit this cycle (ignored while busy)
//   mc_lat_e      its latency in cycles (0 behaves as 1)
//   mc_rd_e       its destination register
//   pending       one bit per register, set while a result is owed
//   mc_busy       unit occupied
//   mc_wb_valid   single-cycle writeback pulse in the last busy cycle
//   mc_wb_rd      destination for the writeback pulse (0 otherwise)
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int RAW   = RAW_DEF,
  parameter int LAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mc_start_e,
  input  logic [LAT_W-1:0] mc_lat_e,
  input  logic [RAW-1:0]   mc_rd_e,
  output logic [NREG-1:0]  pending,
  output logic             mc_busy,
  output logic             mc_wb_valid,
  output logic [RAW-1:0]   mc_wb_rd
);

  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] lat_eff;
  logic [RAW-1:0]   rd_q;
  logic [NREG-1:0]  pending_nxt;
  logic             start_ok;
  logic             last;

  // The counter holds the number of busy cycles still to come,
  // including the current one; the writeback lands when it reads 1.
  assign mc_busy     = (cnt != '0);
  assign last        = (cnt == LAT_W'(1));
  assign mc_wb_valid = last;
  assign mc_wb_rd    = last ? rd_q : '0;

  // A start while busy is dropped; decode stalls keep it from happening.
  assign start_ok = mc_start_e && !mc_busy;
  assign lat_eff  = (mc_lat_e == '0) ? LAT_W'(1) : mc_lat_e;

  // A clear (last busy cycle) and a set (start) never coincide,
  // because a start is only accepted when the unit is idle.
  always_comb begin
    pending_nxt = pending;
    if (last)
      pending_nxt[rd_q] = 1'b0;
    if (start_ok && (mc_rd_e != '0))
      pending_nxt[mc_rd_e] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      rd_q    <= '0;
      pending <= '0;
    end else begin
      if (start_ok) begin
        cnt  <= lat_eff;
        rd_q <= mc_rd_e;
      end else if (mc_busy) begin
        cnt <= cnt - LAT_W'(1);
      end
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard and forwarding controller for a 5-stage RV32 pipeline with
//   NFWD forwarding sources and one variable-latency execution unit.
//   Stall, flush and operand-select outputs are combinational; only the
//   scoreboard, the mc latency counter and the event counters are state.
// Ports
//   clk, rst                clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d      decode register indices
//   rs1_use_d, rs2_use_d    decode instruction reads rs1 / rs2
//   regwrite_d, mc_op_d     decode writes rd / targets the mc unit
//   rs1_e, rs2_e, rd_e      execute register indices
//   regwrite_e, load_e      execute writes rd / is a load
//   fwd_rd, fwd_we          per-source destination (packed) and write enable
//   pcsrc_e                 taken branch/jump resolved in EX
//   mc_start_e/lat_e/rd_e   mc op issue, latency, destination
//   stall_f, stall_d        hold PC / IF_ID
//   flush_d, flush_e        clear IF_ID / ID_EX
//   fwd_a_e, fwd_b_e        operand selects (0 = regfile, k = source k-1)
//   mc_busy, mc_wb_valid, mc_wb_rd   mc unit status and writeback
//   stall_cnt, flush_cnt    saturating counts of stall_d / pcsrc_e cycles
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int RAW   = RAW_DEF,
  parameter int NFWD  = 2,
  parameter int LAT_W = 6,
  parameter int CNT_W = CNT_W_DEF,
  localparam int FSW  = fsw_of(NFWD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RAW-1:0]      rs1_d,
  input  logic [RAW-1:0]      rs2_d,
  input  logic                rs1_use_d,
  input  logic                rs2_use_d,
  input  logic [RAW-1:0]      rd_d,
  input  logic                regwrite_d,
  input  logic                mc_op_d,
  input  logic [RAW-1:0]      rs1_e,
  input  logic [RAW-1:0]      rs2_e,
  input  logic [RAW-1:0]      rd_e,
  input  logic                regwrite_e,
  input  logic                load_e,
  input  logic [NFWD*RAW-1:0] fwd_rd,
  input  logic [NFWD-1:0]     fwd_we,
  input  logic                pcsrc_e,
  input  logic                mc_start_e,
  input  logic [LAT_W-1:0]    mc_lat_e,
  input  logic [RAW-1:0]      mc_rd_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic [FSW-1:0]      fwd_a_e,
  output logic [FSW-1:0]      fwd_b_e,
  output logic                mc_busy,
  output logic                mc_wb_valid,
  output logic [RAW-1:0]      mc_wb_rd,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  logic [NREG-1:0] pending;
  logic            load_use;
  logic            sb_raw;
  logic            sb_waw;
  logic            structural;
  logic            hazard;

  mc_scoreboard #(
    .NREG  (NREG),
    .RAW   (RAW),
    .LAT_W (LAT_W)
  ) u_mc (
    .clk         (clk),
    .rst         (rst),
    .mc_start_e  (mc_start_e),
    .mc_lat_e    (mc_lat_e),
    .mc_rd_e     (mc_rd_e),
    .pending     (pending),
    .mc_busy     (mc_busy),
    .mc_wb_valid (mc_wb_valid),
    .mc_wb_rd    (mc_wb_rd)
  );

  // Walking from oldest to youngest lets the youngest matching source
  // overwrite older ones, so MEM beats WB.
  always_comb begin
    fwd_a_e = FSW'(FWD_RF);
    fwd_b_e = FSW'(FWD_RF);
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_rd[k*RAW +: RAW] == rs1_e) && (rs1_e != '0))
        fwd_a_e = FSW'(k + 1);
      if (fwd_we[k] && (fwd_rd[k*RAW +: RAW] == rs2_e) && (rs2_e != '0))
        fwd_b_e = FSW'(k + 1);
    end
  end

  assign load_use   = load_e && regwrite_e && (rd_e != '0) &&
                      ((rs1_use_d && (rs1_d == rd_e)) ||
                       (rs2_use_d && (rs2_d == rd_e)));
  // pending[0] is never set, so x0 sources need no explicit exclusion.
  assign sb_raw     = (rs1_use_d && pending[rs1_d]) ||
                      (rs2_use_d && pending[rs2_d]);
  assign sb_waw     = regwrite_d && (rd_d != '0) && pending[rd_d];
  assign structural = mc_op_d && (mc_busy || mc_start_e);
  assign hazard     = load_use || sb_raw || sb_waw || structural;

  // A redirect squashes the stalled decode instruction anyway, so it
  // drops the stall and lets the fetch of the new target proceed.
  assign stall_f = hazard && !pcsrc_e;
  assign stall_d = hazard && !pcsrc_e;
  assign flush_d = pcsrc_e;
  assign flush_e = hazard || pcsrc_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pcsrc_e && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  localparam int NREG  = 32;
  localparam int RAW   = 5;
  localparam int NFWD  = 2;
  localparam int LAT_W = 6;
  localparam int CNT_W = 16;
  localparam int FSW   = 2;
  localparam int CNT_MAX = 65535;

  localparam int S_STALL_F = 0;
  localparam int S_STALL_D = 1;
  localparam int S_FLUSH_D = 2;
  localparam int S_FLUSH_E = 3;
  localparam int S_FWD_A   = 4;
  localparam int S_FWD_B   = 5;
  localparam int S_BUSY    = 6;
  localparam int S_WBV     = 7;
  localparam int S_WBRD    = 8;
  localparam int S_SCNT    = 9;
  localparam int S_FCNT    = 10;

  logic                clk;
  logic                rst;
  logic [RAW-1:0]      rs1_d, rs2_d, rd_d;
  logic                rs1_use_d, rs2_use_d, regwrite_d, mc_op_d;
  logic [RAW-1:0]      rs1_e, rs2_e, rd_e;
  logic                regwrite_e, load_e;
  logic [NFWD*RAW-1:0] fwd_rd;
  logic [NFWD-1:0]     fwd_we;
  logic                pcsrc_e, mc_start_e;
  logic [LAT_W-1:0]    mc_lat_e;
  logic [RAW-1:0]      mc_rd_e;
  logic                stall_f, stall_d, flush_d, flush_e;
  logic [FSW-1:0]      fwd_a_e, fwd_b_e;
  logic                mc_busy, mc_wb_valid;
  logic [RAW-1:0]      mc_wb_rd;
  logic [CNT_W-1:0]    stall_cnt, flush_cnt;

  hazard_scoreboard_unit #(
    .NREG (NREG), .RAW (RAW), .NFWD (NFWD), .LAT_W (LAT_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .rs1_d (rs1_d), .rs2_d (rs2_d), .rs1_use_d (rs1_use_d), .rs2_use_d (rs2_use_d),
    .rd_d (rd_d), .regwrite_d (regwrite_d), .mc_op_d (mc_op_d),
    .rs1_e (rs1_e), .rs2_e (rs2_e), .rd_e (rd_e), .regwrite_e (regwrite_e), .load_e (load_e),
    .fwd_rd (fwd_rd), .fwd_we (fwd_we), .pcsrc_e (pcsrc_e),
    .mc_start_e (mc_start_e), .mc_lat_e (mc_lat_e), .mc_rd_e (mc_rd_e),
    .stall_f (stall_f), .stall_d (stall_d), .flush_d (flush_d), .flush_e (flush_e),
    .fwd_a_e (fwd_a_e), .fwd_b_e (fwd_b_e),
    .mc_busy (mc_busy), .mc_wb_valid (mc_wb_valid), .mc_wb_rd (mc_wb_rd),
    .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_scnt = 0;
  int   exp_fcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sig_val(input int id);
    case (id)
      S_STALL_F: return 32'(stall_f);
      S_STALL_D: return 32'(stall_d);
      S_FLUSH_D: return 32'(flush_d);
      S_FLUSH_E: return 32'(flush_e);
      S_FWD_A:   return 32'(fwd_a_e);
      S_FWD_B:   return 32'(fwd_b_e);
      S_BUSY:    return 32'(mc_busy);
      S_WBV:     return 32'(mc_wb_valid);
      S_WBRD:    return 32'(mc_wb_rd);
      S_SCNT:    return 32'(stall_cnt);
      S_FCNT:    return 32'(flush_cnt);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  function automatic string sig_name(input int id);
    case (id)
      S_STALL_F: return "stall_f";
      S_STALL_D: return "stall_d";
      S_FLUSH_D: return "flush_d";
      S_FLUSH_E: return "flush_e";
      S_FWD_A:   return "fwd_a_e";
      S_FWD_B:   return "fwd_b_e";
      S_BUSY:    return "mc_busy";
      S_WBV:     return "mc_wb_valid";
      S_WBRD:    return "mc_wb_rd";
      S_SCNT:    return "stall_cnt";
      S_FCNT:    return "flush_cnt";
      default:   return "unknown";
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic push(input string tag, input int id, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_mc(input string tag, input logic busy, input logic wbv, input logic [RAW-1:0] wbrd);
    push(tag, S_BUSY, 32'(busy));
    push(tag, S_WBV, 32'(wbv));
    if (wbv) push(tag, S_WBRD, 32'(wbrd));
  endtask

  task automatic expect_fwd(input string tag, input int a, input int b);
    push(tag, S_FWD_A, a);
    push(tag, S_FWD_B, b);
  endtask

  // Pushes the stall/flush and counter expectations for the current
  // cycle, then drains the queue against the DUT at the falling edge
  // and advances to just after the next rising edge.
  task automatic cycle(input string tag, input logic sf, input logic sd, input logic fd, input logic fe);
    exp_t e;
    push(tag, S_STALL_F, 32'(sf));
    push(tag, S_STALL_D, 32'(sd));
    push(tag, S_FLUSH_D, 32'(fd));
    push(tag, S_FLUSH_E, 32'(fe));
    push(tag, S_SCNT, exp_scnt);
    push(tag, S_FCNT, exp_fcnt);
    exp_scnt = sat(exp_scnt + int'(sd));
    exp_fcnt = sat(exp_fcnt + int'(fd));
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s.%s", e.tag, sig_name(e.id)), sig_val(e.id), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rd_d = '0;
    rs1_use_d = 1'b0; rs2_use_d = 1'b0; regwrite_d = 1'b0; mc_op_d = 1'b0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; regwrite_e = 1'b0; load_e = 1'b0;
    fwd_rd = '0; fwd_we = '0; pcsrc_e = 1'b0;
    mc_start_e = 1'b0; mc_lat_e = '0; mc_rd_e = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    expect_mc("rst", 1'b0, 1'b0, '0);
    push("rst", S_WBRD, 32'd0);
    cycle("rst", 0, 0, 0, 0);
    rst = 1'b1;
    expect_mc("idle", 1'b0, 1'b0, '0);
    cycle("idle", 0, 0, 0, 0);

    // Forwarding priority
    fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11; rs1_e = 5'd5; rs2_e = 5'd5;
    expect_fwd("fwd_mem", 1, 1);
    cycle("fwd_mem", 0, 0, 0, 0);
    fwd_we = 2'b10;
    expect_fwd("fwd_wb", 2, 2);
    cycle("fwd_wb", 0, 0, 0, 0);
    fwd_rd = {5'd0, 5'd5}; fwd_we = 2'b11; rs1_e = 5'd0; rs2_e = 5'd5;
    expect_fwd("fwd_x0", 0, 1);
    cycle("fwd_x0", 0, 0, 0, 0);
    fwd_rd = {5'd3, 5'd5}; rs1_e = 5'd3; rs2_e = 5'd5;
    expect_fwd("fwd_mix", 2, 1);
    cycle("fwd_mix", 0, 0, 0, 0);
    fwd_we = 2'b00;
    expect_fwd("fwd_off", 0, 0);
    cycle("fwd_off", 0, 0, 0, 0);
    idle();

    // Load-use
    load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; rs2_use_d = 1'b1;
    cycle("lu", 1, 1, 0, 1);
    rs2_use_d = 1'b0;
    cycle("lu_nouse", 0, 0, 0, 0);
    rs2_use_d = 1'b1; regwrite_e = 1'b0;
    cycle("lu_nowr", 0, 0, 0, 0);
    regwrite_e = 1'b1; rd_e = 5'd0; rs2_d = 5'd0;
    cycle("lu_x0", 0, 0, 0, 0);
    idle();

    // Multi-cycle op, latency 4, destination x9
    mc_start_e = 1'b1; mc_lat_e = 6'd4; mc_rd_e = 5'd9;
    expect_mc("mc4_t0", 0, 0, '0);
    cycle("mc4_t0", 0, 0, 0, 0);
    idle(); rs1_d = 5'd9; rs1_use_d = 1'b1;
    expect_mc("mc4_t1", 1, 0, '0);
    cycle("mc4_t1_raw", 1, 1, 0, 1);
    rs1_use_d = 1'b0; regwrite_d = 1'b1; rd_d = 5'd9;
    expect_mc("mc4_t2", 1, 0, '0);
    cycle("mc4_t2_waw", 1, 1, 0, 1);
    regwrite_d = 1'b0; rs2_d = 5'd9; rs2_use_d = 1'b1;
    expect_mc("mc4_t3", 1, 0, '0);
    cycle("mc4_t3_raw2", 1, 1, 0, 1);
    rs2_use_d = 1'b0; rs1_use_d = 1'b1;
    expect_mc("mc4_t4", 1, 1, 5'd9);
    cycle("mc4_t4", 1, 1, 0, 1);
    expect_mc("mc4_t5", 0, 0, '0);
    cycle("mc4_t5", 0, 0, 0, 0);
    idle();

    // Structural stall, latency 3, no destination
    mc_start_e = 1'b1; mc_lat_e = 6'd3; mc_rd_e = 5'd0; mc_op_d = 1'b1;
    expect_mc("st_t0", 0, 0, '0);
    cycle("st_t0", 1, 1, 0, 1);
    mc_start_e = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      expect_mc($sformatf("st_t%0d", i), 1, (i == 3), 5'd0);
      cycle($sformatf("st_t%0d", i), 1, 1, 0, 1);
    end
    rs1_d = 5'd0; rs1_use_d = 1'b1; regwrite_d = 1'b1; rd_d = 5'd0;
    expect_mc("st_t4", 0, 0, '0);
    cycle("st_t4", 0, 0, 0, 0);
    idle();

    // Latency 0 behaves as 1
    mc_start_e = 1'b1; mc_lat_e = 6'd0; mc_rd_e = 5'd12;
    expect_mc("l0_t0", 0, 0, '0);
    cycle("l0_t0", 0, 0, 0, 0);
    idle(); rs1_d = 5'd12; rs1_use_d = 1'b1;
    expect_mc("l0_t1", 1, 1, 5'd12);
    cycle("l0_t1", 1, 1, 0, 1);
    expect_mc("l0_t2", 0, 0, '0);
    cycle("l0_t2", 0, 0, 0, 0);
    idle();

    // Redirect overrides a concurrent scoreboard/structural stall
    mc_start_e = 1'b1; mc_lat_e = 6'd5; mc_rd_e = 5'd10;
    cycle("rd_t0", 0, 0, 0, 0);
    idle(); rs1_d = 5'd10; rs1_use_d = 1'b1; mc_op_d = 1'b1; pcsrc_e = 1'b1;
    expect_mc("rd_t1", 1, 0, '0);
    cycle("rd_t1", 0, 0, 1, 1);
    pcsrc_e = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      expect_mc($sformatf("rd_t%0d", i), 1, (i == 5), 5'd10);
      cycle($sformatf("rd_t%0d", i), 1, 1, 0, 1);
    end
    expect_mc("rd_t6", 0, 0, '0);
    cycle("rd_t6", 0, 0, 0, 0);
    idle(); pcsrc_e = 1'b1;
    cycle("rd_plain", 0, 0, 1, 1);
    idle();
    cycle("rd_after", 0, 0, 0, 0);

    // Asynchronous reset in the middle of an op
    mc_start_e = 1'b1; mc_lat_e = 6'd20; mc_rd_e = 5'd9;
    cycle("ar_t0", 0, 0, 0, 0);
    idle(); rs1_d = 5'd9; rs1_use_d = 1'b1;
    expect_mc("ar_t1", 1, 0, '0);
    cycle("ar_t1", 1, 1, 0, 1);
    rst = 1'b0;
    exp_scnt = 0;
    exp_fcnt = 0;
    expect_mc("ar_rst", 0, 0, '0);
    push("ar_rst", S_WBRD, 32'd0);
    cycle("ar_rst", 0, 0, 0, 0);
    rst = 1'b1;
    expect_mc("ar_post", 0, 0, '0);
    cycle("ar_post", 0, 0, 0, 0);
    idle();

    // Stall counter saturation
    load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7; rs1_use_d = 1'b1;
    cycle("sat_pre", 1, 1, 0, 1);
    repeat (65540) @(posedge clk);
    #1;
    exp_scnt = sat(exp_scnt + 65540);
    cycle("sat_top", 1, 1, 0, 1);
    cycle("sat_hold", 1, 1, 0, 1);
    idle();
    cycle("sat_idle", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
